// File: rtl/am29xx_slice_set_if.sv
// Bus bundle for the Am2901 ALU slice and the Am2909/2911 sequencer slice.
// The master side (datapath/test driver) drives the slice inputs; the
// slave side is the slice set itself.
interface am29xx_slice_set_if;
  // ALU slice inputs
  logic [3:0] alu_din;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_src;
  logic [2:0] alu_op;
  logic [2:0] alu_dest;
  logic       alu_cin;
  logic       ram0_in;
  logic       ram3_in;
  logic       q0_in;
  logic       q3_in;
  // ALU slice outputs
  logic [3:0] alu_y;
  logic       alu_cout;
  logic       alu_zero;
  logic       alu_f3;
  logic       alu_ovr;
  logic       ram0_out;
  logic       ram3_out;
  logic       q0_out;
  logic       q3_out;
  // Sequencer slice inputs
  logic [3:0] seq_din;
  logic [3:0] seq_rin;
  logic [3:0] seq_orin;
  logic       seq_s0;
  logic       seq_s1;
  logic       seq_zero_n;
  logic       seq_cin;
  logic       seq_re_n;
  logic       seq_fe_n;
  logic       seq_pup;
  // Sequencer slice outputs
  logic [3:0] seq_y;
  logic       seq_cout;

  modport master (
    output alu_din, alu_a, alu_b, alu_src, alu_op, alu_dest, alu_cin,
           ram0_in, ram3_in, q0_in, q3_in,
           seq_din, seq_rin, seq_orin, seq_s0, seq_s1, seq_zero_n,
           seq_cin, seq_re_n, seq_fe_n, seq_pup,
    input  alu_y, alu_cout, alu_zero, alu_f3, alu_ovr,
           ram0_out, ram3_out, q0_out, q3_out, seq_y, seq_cout
  );

  modport slave (
    input  alu_din, alu_a, alu_b, alu_src, alu_op, alu_dest, alu_cin,
           ram0_in, ram3_in, q0_in, q3_in,
           seq_din, seq_rin, seq_orin, seq_s0, seq_s1, seq_zero_n,
           seq_cin, seq_re_n, seq_fe_n, seq_pup,
    output alu_y, alu_cout, alu_zero, alu_f3, alu_ovr,
           ram0_out, ram3_out, q0_out, q3_out, seq_y, seq_cout
  );
endinterface

// File: rtl/am29xx_slice_set.sv
// One 4-bit Am2901 ALU slice and one 4-bit Am2909/Am2911 sequencer slice.
// The two slices share only clock and reset; outputs are combinational
// from the held state and the current inputs, as in the original parts.
module am29xx_slice_set #(
  parameter bit IS_2911 = 1'b0  // 1: OR inputs ignored, AR loads from din
) (
  input  logic                 clock,
  input  logic                 reset,
  am29xx_slice_set_if.slave    bus
);

  // ---------------- ALU slice state ----------------
  logic [3:0] ram_q [0:15];
  logic [3:0] q_q;

  logic [3:0] a_data_s, b_data_s;
  logic [3:0] r_s, s_s, opx_s, opy_s, f_s;
  logic [4:0] sum_s;
  logic [3:0] sum_lo_s;
  logic       cout_s, ovr_s;
  logic       ram_we_s, q_we_s;
  logic [3:0] ram_d, q_d;

  assign a_data_s = ram_q[bus.alu_a];
  assign b_data_s = ram_q[bus.alu_b];

  // Operand selection for the R and S inputs of the adder/logic unit
  always_comb begin
    r_s = 4'h0;
    s_s = 4'h0;
    case (bus.alu_src)
      3'd0:    begin r_s = a_data_s;    s_s = q_q;      end
      3'd1:    begin r_s = a_data_s;    s_s = b_data_s; end
      3'd2:    begin r_s = 4'h0;        s_s = q_q;      end
      3'd3:    begin r_s = 4'h0;        s_s = b_data_s; end
      3'd4:    begin r_s = 4'h0;        s_s = a_data_s; end
      3'd5:    begin r_s = bus.alu_din; s_s = a_data_s; end
      3'd6:    begin r_s = bus.alu_din; s_s = q_q;      end
      3'd7:    begin r_s = bus.alu_din; s_s = 4'h0;     end
      default: begin r_s = 4'h0;        s_s = 4'h0;     end
    endcase
  end

  // Adder operand steering: subtracts become additions of the complement
  always_comb begin
    opx_s = r_s;
    opy_s = s_s;
    case (bus.alu_op)
      3'd1:    begin opx_s = s_s; opy_s = ~r_s; end
      3'd2:    begin opx_s = r_s; opy_s = ~s_s; end
      default: begin opx_s = r_s; opy_s = s_s;  end
    endcase
  end

  // Low three bits summed separately to recover the carry into bit 3
  assign sum_lo_s = {1'b0, opx_s[2:0]} + {1'b0, opy_s[2:0]} + {3'b000, bus.alu_cin};
  assign sum_s    = {1'b0, opx_s} + {1'b0, opy_s} + {4'b0000, bus.alu_cin};

  // Function unit: arithmetic ops report carry/overflow, logic ops clear them
  always_comb begin
    f_s    = 4'h0;
    cout_s = 1'b0;
    ovr_s  = 1'b0;
    case (bus.alu_op)
      3'd0, 3'd1, 3'd2: begin
        f_s    = sum_s[3:0];
        cout_s = sum_s[4];
        ovr_s  = sum_lo_s[3] ^ sum_s[4];
      end
      3'd3:    f_s = r_s | s_s;
      3'd4:    f_s = r_s & s_s;
      3'd5:    f_s = ~r_s & s_s;
      3'd6:    f_s = r_s ^ s_s;
      3'd7:    f_s = ~(r_s ^ s_s);
      default: f_s = 4'h0;
    endcase
  end

  // Destination decode: RAM and Q write enables and their shifted data
  always_comb begin
    ram_we_s = 1'b0;
    q_we_s   = 1'b0;
    ram_d    = f_s;
    q_d      = q_q;
    case (bus.alu_dest)
      3'd0:    begin q_we_s = 1'b1; q_d = f_s; end
      3'd1:    begin ram_we_s = 1'b0; end
      3'd2:    begin ram_we_s = 1'b1; ram_d = f_s; end
      3'd3:    begin ram_we_s = 1'b1; ram_d = f_s; end
      3'd4:    begin
        ram_we_s = 1'b1; ram_d = {bus.ram3_in, f_s[3:1]};
        q_we_s   = 1'b1; q_d   = {bus.q3_in, q_q[3:1]};
      end
      3'd5:    begin ram_we_s = 1'b1; ram_d = {bus.ram3_in, f_s[3:1]}; end
      3'd6:    begin
        ram_we_s = 1'b1; ram_d = {f_s[2:0], bus.ram0_in};
        q_we_s   = 1'b1; q_d   = {q_q[2:0], bus.q0_in};
      end
      3'd7:    begin ram_we_s = 1'b1; ram_d = {f_s[2:0], bus.ram0_in}; end
      default: begin ram_we_s = 1'b0; q_we_s = 1'b0; end
    endcase
  end

  // ALU register file and Q register update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram_q[i] <= 4'h0;
      q_q <= 4'h0;
    end else begin
      if (ram_we_s) ram_q[bus.alu_b] <= ram_d;
      if (q_we_s)   q_q <= q_d;
    end
  end

  assign bus.alu_y    = (bus.alu_dest == 3'd2) ? a_data_s : f_s;
  assign bus.alu_cout = cout_s;
  assign bus.alu_ovr  = ovr_s;
  assign bus.alu_zero = (f_s == 4'h0);
  assign bus.alu_f3   = f_s[3];
  assign bus.ram0_out = f_s[0];
  assign bus.ram3_out = f_s[3];
  assign bus.q0_out   = q_q[0];
  assign bus.q3_out   = q_q[3];

  // ---------------- Sequencer slice state ----------------
  logic [3:0] pc_q, ar_q;
  logic [1:0] sp_q;
  logic [3:0] stk_q [0:3];
  logic [3:0] mux_s, seq_y_s;

  // Address source mux, OR-in and zero forcing
  always_comb begin
    mux_s = 4'h0;
    case ({bus.seq_s1, bus.seq_s0})
      2'd0:    mux_s = pc_q;
      2'd1:    mux_s = ar_q;
      2'd2:    mux_s = stk_q[sp_q];
      2'd3:    mux_s = bus.seq_din;
      default: mux_s = 4'h0;
    endcase
    if (!bus.seq_zero_n) begin
      seq_y_s = 4'h0;
    end else if (IS_2911) begin
      seq_y_s = mux_s;
    end else begin
      seq_y_s = mux_s | bus.seq_orin;
    end
  end

  // PC increment, AR load and stack push/pop
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q <= 4'h0;
      ar_q <= 4'h0;
      sp_q <= 2'd0;
      for (int i = 0; i < 4; i++) stk_q[i] <= 4'h0;
    end else begin
      pc_q <= seq_y_s + {3'b000, bus.seq_cin};
      if (!bus.seq_re_n) ar_q <= IS_2911 ? bus.seq_din : bus.seq_rin;
      if (!bus.seq_fe_n) begin
        if (bus.seq_pup) begin
          sp_q                 <= sp_q + 2'd1;
          stk_q[sp_q + 2'd1]   <= pc_q;
        end else begin
          sp_q <= sp_q - 2'd1;
        end
      end
    end
  end

  assign bus.seq_y    = seq_y_s;
  assign bus.seq_cout = (seq_y_s == 4'hF) & bus.seq_cin;

endmodule

// File: tb/tb_am29xx_slice_set.sv
// Directed bench for am29xx_slice_set: hand-computed vectors for the ALU
// and sequencer slices, checked with immediate assertions.
module tb_am29xx_slice_set;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  am29xx_slice_set_if bus ();

  am29xx_slice_set #(.IS_2911(1'b0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic alu(input logic [2:0] src, input logic [2:0] op, input logic [2:0] dest,
                     input logic [3:0] d, input logic [3:0] a, input logic [3:0] b,
                     input logic cin);
    bus.alu_src = src; bus.alu_op = op; bus.alu_dest = dest;
    bus.alu_din = d;   bus.alu_a = a;   bus.alu_b = b; bus.alu_cin = cin;
    #1;
  endtask

  task automatic seq(input logic [1:0] s, input logic [3:0] din, input logic cin,
                     input logic fe_n, input logic pup);
    {bus.seq_s1, bus.seq_s0} = s;
    bus.seq_din = din; bus.seq_cin = cin; bus.seq_fe_n = fe_n; bus.seq_pup = pup;
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.ram0_in = 1'b0; bus.ram3_in = 1'b0; bus.q0_in = 1'b0; bus.q3_in = 1'b0;
    bus.seq_rin = 4'h0; bus.seq_orin = 4'h0; bus.seq_zero_n = 1'b1; bus.seq_re_n = 1'b1;
    seq(2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    alu(3'd3, 3'd0, 3'd1, 4'h0, 4'h0, 4'h7, 1'b0);

    // Reset state
    chk("rst_alu_y", {4'h0, bus.alu_y}, 8'h00);
    chk("rst_alu_zero", {7'h0, bus.alu_zero}, 8'h01);
    chk("rst_seq_y", {4'h0, bus.seq_y}, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Write D=5 to RAM[2], read it back
    alu(3'd7, 3'd0, 3'd3, 4'h5, 4'h0, 4'h2, 1'b0);
    chk("wr_y", {4'h0, bus.alu_y}, 8'h05);
    tick();
    alu(3'd3, 3'd0, 3'd1, 4'h0, 4'h0, 4'h2, 1'b0);
    chk("rd_y", {4'h0, bus.alu_y}, 8'h05);
    chk("rd_zero", {7'h0, bus.alu_zero}, 8'h00);

    // RAM[1]=7, then D+A with overflow into the sign bit
    alu(3'd7, 3'd0, 3'd3, 4'h7, 4'h0, 4'h1, 1'b0);
    tick();
    alu(3'd5, 3'd0, 3'd1, 4'h1, 4'h1, 4'h0, 1'b0);
    chk("add8_y", {4'h0, bus.alu_y}, 8'h08);
    chk("add8_flags", {4'h0, bus.alu_cout, bus.alu_ovr, bus.alu_f3, bus.alu_zero}, 8'h06);
    alu(3'd5, 3'd0, 3'd1, 4'h9, 4'h1, 4'h0, 1'b0);
    chk("add16_y", {4'h0, bus.alu_y}, 8'h00);
    chk("add16_flags", {4'h0, bus.alu_cout, bus.alu_ovr, bus.alu_f3, bus.alu_zero}, 8'h09);

    // RAM[1]=5; R=D=3, S=A=5
    alu(3'd7, 3'd0, 3'd3, 4'h5, 4'h0, 4'h1, 1'b0);
    tick();
    alu(3'd5, 3'd2, 3'd1, 4'h3, 4'h1, 4'h0, 1'b1);
    chk("subs_y", {4'h0, bus.alu_y}, 8'h0E);
    chk("subs_cout", {7'h0, bus.alu_cout}, 8'h00);
    alu(3'd5, 3'd1, 3'd1, 4'h3, 4'h1, 4'h0, 1'b1);
    chk("subr_y", {4'h0, bus.alu_y}, 8'h02);
    chk("subr_cout", {7'h0, bus.alu_cout}, 8'h01);
    alu(3'd5, 3'd6, 3'd1, 4'hA, 4'h1, 4'h0, 1'b1);
    chk("xor_y_cout", {3'h0, bus.alu_cout, bus.alu_y}, 8'h0F);
    alu(3'd5, 3'd5, 3'd1, 4'h3, 4'h1, 4'h0, 1'b0);
    chk("notrs_y", {4'h0, bus.alu_y}, 8'h04);

    // Up-shift F=1001 into RAM[3] with ram0_in=1
    bus.ram0_in = 1'b1;
    alu(3'd7, 3'd0, 3'd6, 4'h9, 4'h0, 4'h3, 1'b0);
    chk("shu_ram3_out", {7'h0, bus.ram3_out}, 8'h01);
    chk("shu_ram0_out", {7'h0, bus.ram0_out}, 8'h01);
    tick();
    bus.ram0_in = 1'b0;
    alu(3'd3, 3'd0, 3'd1, 4'h0, 4'h0, 4'h3, 1'b0);
    chk("shu_ram", {4'h0, bus.alu_y}, 8'h03);

    // Q=0110, then down-shift Q with q3_in=0 and RAM[4]={1,F[3:1]}
    alu(3'd7, 3'd0, 3'd0, 4'h6, 4'h0, 4'h0, 1'b0);
    tick();
    bus.ram3_in = 1'b1;
    bus.q3_in   = 1'b0;
    alu(3'd7, 3'd0, 3'd4, 4'h6, 4'h0, 4'h4, 1'b0);
    chk("shd_q0_out", {7'h0, bus.q0_out}, 8'h00);
    chk("shd_q3_out", {7'h0, bus.q3_out}, 8'h00);
    tick();
    bus.ram3_in = 1'b0;
    alu(3'd2, 3'd0, 3'd1, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("shd_q", {4'h0, bus.alu_y}, 8'h03);
    chk("shd_q0_after", {7'h0, bus.q0_out}, 8'h01);
    alu(3'd3, 3'd0, 3'd1, 4'h0, 4'h0, 4'h4, 1'b0);
    chk("shd_ram", {4'h0, bus.alu_y}, 8'h0B);

    // RAMA dest with A==B: Y is the pre-edge RAM value
    alu(3'd7, 3'd0, 3'd2, 4'h1, 4'h4, 4'h4, 1'b0);
    chk("rama_y", {4'h0, bus.alu_y}, 8'h0B);
    tick();
    chk("rama_after", {4'h0, bus.alu_y}, 8'h01);

    // Sequencer: din=F, cin=1 wraps PC to 0
    seq(2'd3, 4'hF, 1'b1, 1'b1, 1'b0);
    chk("seq_din_y", {4'h0, bus.seq_y}, 8'h0F);
    chk("seq_cout", {7'h0, bus.seq_cout}, 8'h01);
    tick();
    seq(2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("seq_pc_wrap", {4'h0, bus.seq_y}, 8'h00);

    // PC=4, push it, then PC=7
    seq(2'd3, 4'h3, 1'b1, 1'b1, 1'b0);
    tick();
    seq(2'd0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("seq_pc4", {4'h0, bus.seq_y}, 8'h04);
    tick();
    seq(2'd3, 4'h7, 1'b0, 1'b1, 1'b0);
    tick();
    seq(2'd2, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("stk_top4", {4'h0, bus.seq_y}, 8'h04);
    // Push PC=7 with s=2: Y still shows the pre-push top
    seq(2'd2, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("stk_prepush", {4'h0, bus.seq_y}, 8'h04);
    tick();
    seq(2'd2, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("stk_top7", {4'h0, bus.seq_y}, 8'h07);
    // Pop back to the earlier entries
    seq(2'd2, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("stk_pop1", {4'h0, bus.seq_y}, 8'h04);
    tick();
    chk("stk_pop0", {4'h0, bus.seq_y}, 8'h00);
    seq(2'd2, 4'h0, 1'b0, 1'b1, 1'b0);

    // AR load, OR-in, zero forcing
    bus.seq_rin  = 4'h9;
    bus.seq_re_n = 1'b0;
    tick();
    bus.seq_re_n = 1'b1;
    bus.seq_rin  = 4'h0;
    seq(2'd1, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("ar_y", {4'h0, bus.seq_y}, 8'h09);
    bus.seq_orin = 4'b0010;
    seq(2'd3, 4'h8, 1'b0, 1'b1, 1'b0);
    chk("orin_y", {4'h0, bus.seq_y}, 8'h0A);
    bus.seq_zero_n = 1'b0;
    seq(2'd3, 4'hF, 1'b1, 1'b1, 1'b0);
    chk("zero_y", {4'h0, bus.seq_y}, 8'h00);
    chk("zero_cout", {7'h0, bus.seq_cout}, 8'h00);
    tick();
    bus.seq_zero_n = 1'b1;
    bus.seq_orin   = 4'h0;
    seq(2'd0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("zero_pc", {4'h0, bus.seq_y}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
